// File: rtl/sump_pkg.sv
// Shared opcode map, FSM state encoding and strobe bundle for the SUMP
// command path (decoder, opcode map, metadata responder).
package sump_pkg;

    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_ARM       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_META      = 8'h04;
    localparam logic [7:0] OP_FINISH    = 8'h05;
    localparam logic [7:0] OP_DIVIDER   = 8'h80;
    localparam logic [7:0] OP_SIZE      = 8'h81;
    localparam logic [7:0] OP_FLAGS     = 8'h82;
    localparam logic [7:0] OP_TRIG_MASK = 8'hC0;
    localparam logic [7:0] OP_TRIG_VAL  = 8'hC1;
    localparam logic [7:0] OP_TRIG_CFG  = 8'hC2;

    // Trigger opcodes carry the stage number in bits [3:2]; masking those
    // bits out leaves the base value of the trigger register kind.
    localparam logic [7:0] OP_TRIG_SEL  = 8'hF3;

    // Argument bytes following a long (bit 7 set) opcode.
    localparam int ARG_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARGS = 2'd1,
        EMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic       soft_reset;
        logic       arm;
        logic       send_id;
        logic       send_meta;
        logic       finish_now;
        logic       wr_divider;
        logic       wr_size;
        logic       wr_flags;
        logic [3:0] trig_mask;
        logic [3:0] trig_val;
        logic [3:0] trig_cfg;
    } strobe_t;

    function automatic logic [3:0] stage_onehot(input logic [1:0] stage);
        return 4'b0001 << stage;
    endfunction

endpackage

// File: rtl/sump_opcode_decode.sv
// Combinational opcode to one-hot strobe map. Unknown opcodes give no strobe.
module sump_opcode_decode
    import sump_pkg::*;
(
    input  logic [7:0] opcode_i,
    output strobe_t    strobe_o
);

    // Decode fixed opcodes directly; trigger opcodes by kind plus stage.
    always_comb begin
        strobe_o = '0;
        case (opcode_i)
            OP_RESET:   strobe_o.soft_reset = 1'b1;
            OP_ARM:     strobe_o.arm        = 1'b1;
            OP_ID:      strobe_o.send_id    = 1'b1;
            OP_META:    strobe_o.send_meta  = 1'b1;
            OP_FINISH:  strobe_o.finish_now = 1'b1;
            OP_DIVIDER: strobe_o.wr_divider = 1'b1;
            OP_SIZE:    strobe_o.wr_size    = 1'b1;
            OP_FLAGS:   strobe_o.wr_flags   = 1'b1;
            default: begin
                if ((opcode_i & OP_TRIG_SEL) == OP_TRIG_MASK) begin
                    strobe_o.trig_mask = stage_onehot(opcode_i[3:2]);
                end else if ((opcode_i & OP_TRIG_SEL) == OP_TRIG_VAL) begin
                    strobe_o.trig_val = stage_onehot(opcode_i[3:2]);
                end else if ((opcode_i & OP_TRIG_SEL) == OP_TRIG_CFG) begin
                    strobe_o.trig_cfg = stage_onehot(opcode_i[3:2]);
                end
            end
        endcase
    end

endmodule

// File: rtl/sump_cmd_decoder.sv
// Assembles SUMP command bytes from the UART receiver into short and long
// commands and issues registered one-cycle strobes to the config registers.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ARGS  | collecting the 4 little-endian argument bytes of a long command
// EMIT  | one cycle: load opcode/config_data/strobes; may accept next opcode
module sump_cmd_decoder
    import sump_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMO_W          = 20
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] config_data,
    output logic [7:0]  opcode,
    output logic        cmd_valid,
    output logic        soft_reset,
    output logic        arm,
    output logic        send_id,
    output logic        send_meta,
    output logic        finish_now,
    output logic        wrDivider,
    output logic        wrsize,
    output logic        wrFlags,
    output logic [3:0]  wrtrigmask,
    output logic [3:0]  wrtrigval,
    output logic [3:0]  wrtrigcfg
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       CNT_LAST = 3'(ARG_BYTES - 1);

    state_e           state_q, state_d;
    logic [7:0]       opc_hold_q, opc_hold_d;
    logic [31:0]      arg_q, arg_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [31:0]      cfg_q, cfg_d;
    logic             cmd_valid_q, cmd_valid_d;
    strobe_t          stb_q, stb_d, stb_dec;

    sump_opcode_decode u_decode (
        .opcode_i (opc_hold_q),
        .strobe_o (stb_dec)
    );

    // Next-state, byte assembly, inter-byte timeout and output load.
    always_comb begin
        state_d     = state_q;
        opc_hold_d  = opc_hold_q;
        arg_d       = arg_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        opcode_d    = opcode_q;
        cfg_d       = cfg_q;
        cmd_valid_d = 1'b0;
        stb_d       = '0;

        case (state_q)
            IDLE: ;
            ARGS: begin
                if (rx_valid) begin
                    // Shift in from the top so the first byte ends in [7:0].
                    arg_d = {rx_data, arg_q[31:8]};
                    cnt_d = cnt_q + 3'd1;
                    tmo_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = EMIT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            EMIT: begin
                opcode_d    = opc_hold_q;
                cmd_valid_d = 1'b1;
                stb_d       = stb_dec;
                if (opc_hold_q[7]) begin
                    cfg_d = arg_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An opcode byte arriving during EMIT starts the next command at once.
        if (rx_valid && (state_q == IDLE || state_q == EMIT)) begin
            opc_hold_d = rx_data;
            cnt_d      = '0;
            tmo_d      = '0;
            state_d    = rx_data[7] ? ARGS : EMIT;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (extReset) begin
            state_q     <= IDLE;
            opc_hold_q  <= '0;
            arg_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            opcode_q    <= '0;
            cfg_q       <= '0;
            cmd_valid_q <= 1'b0;
            stb_q       <= '0;
        end else begin
            state_q     <= state_d;
            opc_hold_q  <= opc_hold_d;
            arg_q       <= arg_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            opcode_q    <= opcode_d;
            cfg_q       <= cfg_d;
            cmd_valid_q <= cmd_valid_d;
            stb_q       <= stb_d;
        end
    end

    assign config_data = cfg_q;
    assign opcode      = opcode_q;
    assign cmd_valid   = cmd_valid_q;
    assign soft_reset  = stb_q.soft_reset;
    assign arm         = stb_q.arm;
    assign send_id     = stb_q.send_id;
    assign send_meta   = stb_q.send_meta;
    assign finish_now  = stb_q.finish_now;
    assign wrDivider   = stb_q.wr_divider;
    assign wrsize      = stb_q.wr_size;
    assign wrFlags     = stb_q.wr_flags;
    assign wrtrigmask  = stb_q.trig_mask;
    assign wrtrigval   = stb_q.trig_val;
    assign wrtrigcfg   = stb_q.trig_cfg;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Scoreboard bench for sump_cmd_decoder: a byte-level model pushes the
// expected command outcome when the final byte is driven; a negedge monitor
// pops and compares whenever the DUT shows any strobe or cmd_valid.
module tb_sump_cmd_decoder;

    localparam int T_OUT = 50;

    logic        clock = 1'b0;
    logic        extReset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] config_data;
    logic [7:0]  opcode;
    logic        cmd_valid, soft_reset, arm, send_id, send_meta, finish_now;
    logic        wrDivider, wrsize, wrFlags;
    logic [3:0]  wrtrigmask, wrtrigval, wrtrigcfg;
    logic [19:0] obs;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          due;
        logic [7:0]  opc;
        logic [31:0] cfg;
        logic [19:0] stb;
    } exp_t;

    exp_t sbq[$];

    logic        m_busy;
    logic [7:0]  m_opc;
    int          m_cnt;
    logic [31:0] m_arg;
    logic [31:0] m_cfg;

    sump_cmd_decoder #(.TIMEOUT_CYCLES(T_OUT), .TMO_W(6)) dut (
        .clock       (clock),
        .extReset    (extReset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .config_data (config_data),
        .opcode      (opcode),
        .cmd_valid   (cmd_valid),
        .soft_reset  (soft_reset),
        .arm         (arm),
        .send_id     (send_id),
        .send_meta   (send_meta),
        .finish_now  (finish_now),
        .wrDivider   (wrDivider),
        .wrsize      (wrsize),
        .wrFlags     (wrFlags),
        .wrtrigmask  (wrtrigmask),
        .wrtrigval   (wrtrigval),
        .wrtrigcfg   (wrtrigcfg)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign obs = {soft_reset, arm, send_id, send_meta, finish_now,
                  wrDivider, wrsize, wrFlags, wrtrigmask, wrtrigval, wrtrigcfg};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [19:0] exp_stb(input logic [7:0] op);
        logic [19:0] v;
        logic [3:0]  st;
        v  = '0;
        st = 4'b0001 << ((op - 8'hC0) / 4);
        case (op)
            8'h00: v[19] = 1'b1;
            8'h01: v[18] = 1'b1;
            8'h02: v[17] = 1'b1;
            8'h04: v[16] = 1'b1;
            8'h05: v[15] = 1'b1;
            8'h80: v[14] = 1'b1;
            8'h81: v[13] = 1'b1;
            8'h82: v[12] = 1'b1;
            8'hC0, 8'hC4, 8'hC8, 8'hCC: v[11:8] = st;
            8'hC1, 8'hC5, 8'hC9, 8'hCD: v[7:4]  = st;
            8'hC2, 8'hC6, 8'hCA, 8'hCE: v[3:0]  = st;
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.due = cyc + 2;
        e.opc = m_opc;
        e.cfg = m_cfg;
        e.stb = exp_stb(m_opc);
        sbq.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_busy) begin
            m_opc = b;
            if (b[7]) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_arg  = '0;
            end else begin
                push_exp();
            end
        end else begin
            m_arg[8*m_cnt +: 8] = b;
            m_cnt++;
            if (m_cnt == 4) begin
                m_busy = 1'b0;
                m_cfg  = m_arg;
                push_exp();
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send5(input logic [7:0] op, input logic [31:0] arg);
        send(op);
        for (int i = 0; i < 4; i++) send(arg[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clock);
        chk("drain", sbq.size(), 0);
    endtask

    task automatic do_reset();
        extReset = 1'b1;
        @(negedge clock);
        extReset = 1'b0;
        m_busy   = 1'b0;
        m_cfg    = '0;
        chk("rst_config_data", config_data, 32'h0);
        chk("rst_opcode", {24'h0, opcode}, 32'h0);
        chk("rst_outputs", {11'h0, cmd_valid, obs}, 32'h0);
    endtask

    // Compare every DUT output event against the scoreboard head.
    always @(negedge clock) begin
        exp_t e;
        if (cmd_valid || obs != 20'h0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", {11'h0, cmd_valid, obs}, 32'h0);
            end else begin
                e = sbq.pop_front();
                chk("due_cycle", cyc, e.due);
                chk("opcode", {24'h0, opcode}, {24'h0, e.opc});
                chk("config_data", config_data, e.cfg);
                chk("strobes", {12'h0, obs}, {12'h0, e.stb});
                chk("cmd_valid", {31'h0, cmd_valid}, 32'h1);
            end
        end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
            e = sbq.pop_front();
            chk("missing_out", cyc, e.due);
        end
    end

    initial begin
        logic [7:0] ops [15];
        ops = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h80, 8'h81, 8'h82,
                8'hC0, 8'hC5, 8'hCA, 8'hCF, 8'h03, 8'h9F, 8'hC3};
        m_busy   = 1'b0;
        m_opc    = '0;
        m_cnt    = 0;
        m_arg    = '0;
        m_cfg    = '0;
        extReset = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(2);
        do_reset();
        idle(2);

        // Flags write, then an immediate short command accepted during EMIT.
        send5(8'h82, 32'h0000_1234);
        send(8'h05);
        send(8'h00);
        send(8'h01);
        send(8'h02);
        send(8'h04);
        drain();
        chk("cfg_kept_after_short", config_data, 32'h0000_1234);

        // Trigger writes across stages and kinds.
        send5(8'hC9, 32'hDDCC_BBAA);
        idle(1);
        send5(8'hC0, 32'h0102_0304);
        send5(8'hC6, 32'hFFFF_0000);
        send5(8'hCE, 32'h8000_0001);
        send5(8'h80, 32'h0000_00FF);
        drain();

        // Partial long command dropped after exactly T_OUT idle clocks.
        send(8'h81);
        send(8'h01);
        send(8'h02);
        idle(T_OUT);
        m_busy = 1'b0;
        send(8'h02);
        drain();

        // One clock short of the timeout the command still completes.
        send(8'h81);
        send(8'h01);
        send(8'h02);
        idle(T_OUT - 1);
        send(8'h03);
        send(8'h04);
        drain();

        // Reset in the middle of a divider write.
        send(8'h80);
        send(8'h11);
        send(8'h22);
        do_reset();
        send(8'h00);
        drain();

        // Unknown opcodes, short and long.
        send(8'h03);
        send5(8'h9F, 32'hCAFE_F00D);
        send5(8'hC3, 32'h1357_9BDF);
        drain();

        // Mixed random stream with short gaps between bytes.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            op = ops[$urandom_range(0, 14)];
            send(op);
            if (op[7]) begin
                for (int j = 0; j < 4; j++) begin
                    idle($urandom_range(0, 2));
                    send(8'($urandom));
                end
            end
            idle($urandom_range(0, 1));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
- Assembles SUMP command bytes from the UART receiver into short (1-byte) and long (5-byte) commands.
- Issues one-cycle write/action strobes, with a 32-bit config_data word, to the configuration registers: flags, divider, size and trigger stages.
- It is the writer side of the wrFlags/config_data interface consumed by the flags register and its peer registers.
- It sits between the UART receiver and the core configuration registers.

Parameters:
- TIMEOUT_CYCLES, 1000000, number of idle clocks allowed between argument bytes before a partial long command is discarded.
- TMO_W, 20, width of the inter-byte timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock.
- extReset  input  1  synchronous active-high reset.
- rx_valid  input  1  one-cycle pulse; rx_data is valid this cycle.
- rx_data  input  8  received byte.
- config_data  output  32  argument word of the most recent long command.
- opcode  output  8  opcode of the most recent completed command.
- cmd_valid  output  1  one-cycle pulse for every completed command, known or unknown.
- soft_reset  output  1  pulse, opcode 0x00.
- arm  output  1  pulse, opcode 0x01.
- send_id  output  1  pulse, opcode 0x02.
- send_meta  output  1  pulse, opcode 0x04.
- finish_now  output  1  pulse, opcode 0x05.
- wrDivider  output  1  pulse, opcode 0x80.
- wrsize  output  1  pulse, opcode 0x81.
- wrFlags  output  1  pulse, opcode 0x82.
- wrtrigmask  output  4  one-hot pulse, opcodes 0xC0/C4/C8/CC (stage 0..3).
- wrtrigval  output  4  one-hot pulse, opcodes 0xC1/C5/C9/CD.
- wrtrigcfg  output  4  one-hot pulse, opcodes 0xC2/C6/CA/CE.

Behaviour:
- Reset: one clock, synchronous and active-high.
  - Every output resets to 0, including config_data and opcode.
  - The state machine goes to IDLE, and the byte counter and timeout counter clear.
  - Reset mid-command discards the partial command; no strobe is issued.
- State IDLE:
  - On rx_valid, latch rx_data into an opcode holding register.
  - If rx_data[7] == 0, it is a short command: go to EMIT.
  - Otherwise it is a long command: go to ARGS with byte count 0.
- State ARGS:
  - On rx_valid, shift rx_data into a 32-bit argument holding register, little-endian: the first byte lands in [7:0], the fourth in [31:24]. Increment the count.
  - After the fourth byte go to EMIT.
  - The timeout counter clears on each rx_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES with no byte: return to IDLE, discard the partial command, no strobe.
- State EMIT (exactly one cycle):
  - opcode takes the holding register.
  - For long commands only, config_data takes the argument holding register. Short commands leave config_data unchanged.
  - Exactly one decoded strobe (or none for an unknown opcode) and cmd_valid are asserted for this cycle only.
  - Then return to IDLE.
- Latency:
  - Strobe and cmd_valid are registered outputs, high in the cycle after EMIT is entered, i.e. two clocks after the rx_valid of the final byte.
  - config_data and opcode change in the same cycle the strobe rises. They are held stable until the next completed command, so receivers may sample config_data on the strobe.
- rx_valid while in EMIT:
  - The byte is accepted as the first byte of the next command; the state goes straight to ARGS or EMIT per bit 7.
  - No byte is ever dropped at back-to-back rate.
- Unknown opcodes (short or long):
  - Only cmd_valid pulses, with opcode updated.
  - A long unknown still consumes 4 argument bytes and updates config_data.
- Strobes are mutually exclusive; at most one bit of all strobe outputs is high in any cycle.
- rx_data is ignored when rx_valid is low.

Decomposition:
- Shared package sump_pkg:
  - opcode constants (OP_RESET, OP_ARM, OP_ID, OP_META, OP_FINISH, OP_DIVIDER, OP_SIZE, OP_FLAGS, OP_TRIG_MASK/VAL/CFG base values);
  - the state enum {IDLE, ARGS, EMIT};
  - the long-command argument byte count constant (4).
- Sub-module sump_opcode_decode: purely combinational opcode-to-one-hot-strobe map, registered by the parent. It is reusable by the metadata responder.

Test Plan:
- Bytes 0x82, 0x34, 0x12, 0x00, 0x00 at back-to-back rate -> a single wrFlags pulse 2 clocks after the last byte; config_data = 0x00001234; opcode = 0x82; cmd_valid high in the same cycle.
- Short 0x05 after the previous long command -> finish_now and cmd_valid one-cycle pulse; config_data remains 0x00001234.
- 0xC9, 0xAA, 0xBB, 0xCC, 0xDD -> wrtrigval = 4'b0100 for one cycle; config_data = 0xDDCCBBAA.
- 0x81, 0x01, 0x02, then TIMEOUT_CYCLES idle clocks, then 0x02 -> no wrsize; a later send_id pulse; config_data unchanged.
- extReset asserted after 2 argument bytes of 0x80 -> no wrDivider, all outputs 0. Then 0x00 -> soft_reset pulse.
- Opcode 0x03 -> cmd_valid pulse with opcode = 0x03 and no other strobe. Opcode 0x9F plus 4 bytes -> cmd_valid only, config_data updated.
